// File: rtl/peridot_cam_burstwriter_if.sv
// Avalon-MM burst write bundle between the frame writer and the memory slave.
interface peridot_cam_burstwriter_if;
    logic [31:0] avm_m1_address;
    logic        avm_m1_write;
    logic [31:0] avm_m1_writedata;
    logic [3:0]  avm_m1_byteenable;
    logic [4:0]  avm_m1_burstcount;
    logic        avm_m1_waitrequest;

    modport master (
        output avm_m1_address,
        output avm_m1_write,
        output avm_m1_writedata,
        output avm_m1_byteenable,
        output avm_m1_burstcount,
        input  avm_m1_waitrequest
    );

    modport slave (
        input  avm_m1_address,
        input  avm_m1_write,
        input  avm_m1_writedata,
        input  avm_m1_byteenable,
        input  avm_m1_burstcount,
        output avm_m1_waitrequest
    );
endinterface

// File: rtl/peridot_cam_burstwriter.sv
// Camera frame writer: drains a show-ahead FIFO into memory as
// 16-beat Avalon-MM bursts, one burst per 64-byte line segment.
module peridot_cam_burstwriter #(
    parameter int FIFO_USEDW_WIDTH = 9
) (
    input  logic                        csi_global_reset_n,
    input  logic                        avm_m1_clk,
    input  logic                        start,
    input  logic [31:0]                 capaddress_top,
    input  logic [15:0]                 capcycle_num,
    output logic                        done,
    input  logic [FIFO_USEDW_WIDTH-1:0] fifo_usedw,
    input  logic [31:0]                 fifo_q,
    output logic                        fifo_rdack,
    peridot_cam_burstwriter_if.master   avm_m1
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        HOLD
    } state_t;

    localparam logic [FIFO_USEDW_WIDTH-1:0] BURST_WORDS =
        FIFO_USEDW_WIDTH'(16);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [3:0]  beat_q, beat_d;
    logic [2:0]  hold_q, hold_d;
    logic        accept;

    assign accept = (state_q == BURST) && !avm_m1.avm_m1_waitrequest;

    always_ff @(posedge avm_m1_clk or negedge csi_global_reset_n) begin
        if (!csi_global_reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            beat_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            beat_q   <= beat_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        beat_d   = beat_q;
        hold_d   = hold_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = capaddress_top;
                    remain_d = capcycle_num;
                    beat_d   = '0;
                    if (capcycle_num != 16'd0) begin
                        state_d = WAIT;
                    end else begin
                        // empty frame: one entry clock ahead of the 4-clock hold
                        state_d = HOLD;
                        hold_d  = 3'd7;
                    end
                end
            end
            WAIT: begin
                if (fifo_usedw >= BURST_WORDS) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'hF) begin
                        addr_d   = addr_q + 32'd64;
                        remain_d = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            state_d = HOLD;
                            hold_d  = 3'd0;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            HOLD: begin
                // long enough for a 3-flop synchronizer to see done rise
                hold_d = hold_q + 3'd1;
                if (hold_q == 3'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done                     = (state_q == IDLE);
    assign fifo_rdack               = accept;
    assign avm_m1.avm_m1_write      = (state_q == BURST);
    assign avm_m1.avm_m1_address    = addr_q;
    assign avm_m1.avm_m1_writedata  = fifo_q;
    assign avm_m1.avm_m1_byteenable = 4'b1111;
    assign avm_m1.avm_m1_burstcount = 5'd16;

endmodule

// File: doc/peridot_cam_burstwriter.md
PERIDOT_CAM_BURSTWRITER -- requirements
Module: peridot_cam_burstwriter

Interface
REQ-001 The block SHALL have one parameter: FIFO_USEDW_WIDTH, default 9, width of the input FIFO fill-level port.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 csi_global_reset_n  in  1  asynchronous active-low reset.
REQ-004 avm_m1_clk  in  1  clock for all logic; all state changes on its rising edge.
REQ-005 start  in  1  single-cycle '1' pulse that begins a frame capture.
REQ-006 capaddress_top  in  32  frame destination byte address; bits 5:0 are always 0.
REQ-007 capcycle_num  in  16  number of 64-byte bursts in the frame.
REQ-008 done  out  1  '1' when idle; '0' while a frame is in progress.
REQ-009 fifo_usedw  in  FIFO_USEDW_WIDTH  number of words in the show-ahead input FIFO.
REQ-010 fifo_q  in  32  FIFO head word.
REQ-011 fifo_rdack  out  1  pops one FIFO word.
REQ-012 avm_m1_address  out  32  burst byte address.
REQ-013 avm_m1_write  out  1  Avalon-MM write request.
REQ-014 avm_m1_writedata  out  32  write data.
REQ-015 avm_m1_byteenable  out  4  byte enables, constant 4'b1111.
REQ-016 avm_m1_burstcount  out  5  burst length, constant 16.
REQ-017 avm_m1_waitrequest  in  1  Avalon-MM slave stall.

Function
REQ-018 The controller SHALL have four states: IDLE, WAIT, BURST and HOLD.
REQ-019 In IDLE, done SHALL be 1, avm_m1_write SHALL be 0 and fifo_rdack SHALL be 0.
REQ-020 In IDLE, start=1 SHALL latch capaddress_top into the address register and capcycle_num into the remaining-cycle counter.
REQ-021 On that start, the controller SHALL go to WAIT when capcycle_num is nonzero, and to HOLD when capcycle_num is 0.
REQ-022 done SHALL fall in the first clock after an accepted start.
REQ-023 start SHALL be ignored in every state other than IDLE, and latched values SHALL NOT change mid-frame.
REQ-024 In WAIT, when fifo_usedw >= 16, the controller SHALL go to BURST on the next clock; otherwise it SHALL remain in WAIT indefinitely with no timeout.
REQ-025 In BURST, avm_m1_write SHALL be 1 continuously until all 16 beats are accepted.
REQ-026 In BURST, avm_m1_address SHALL hold the burst base address and avm_m1_burstcount SHALL hold 16 for the whole burst.
REQ-027 avm_m1_writedata SHALL equal fifo_q combinationally.
REQ-028 A beat SHALL be accepted when avm_m1_write=1 and avm_m1_waitrequest=0.
REQ-029 fifo_rdack SHALL equal the beat-accept condition combinationally, and SHALL never assert otherwise.
REQ-030 A 4-bit beat counter SHALL increment on each accepted beat.
REQ-031 On the 16th accepted beat, the beat counter SHALL return to 0.
REQ-032 On the 16th accepted beat, the address register SHALL add 64, wrapping modulo 2^32.
REQ-033 On the 16th accepted beat, the remaining-cycle counter SHALL decrement by 1.
REQ-034 After the 16th accepted beat, the controller SHALL go to HOLD if the counter reaches 0, and to WAIT otherwise.
REQ-035 avm_m1_write SHALL deassert for at least one clock between bursts.
REQ-036 While waitrequest=1, avm_m1_address, avm_m1_writedata, avm_m1_burstcount and avm_m1_write SHALL remain stable.
REQ-037 In HOLD, done SHALL be 0 for exactly 4 clocks, then the controller SHALL go to IDLE with done=1.
REQ-038 The HOLD period SHALL guarantee that a 3-flop synchronizer in another clock domain detects a rising edge on done.
REQ-039 capcycle_num=0 SHALL produce no write cycles and SHALL give a done low pulse of 5 clocks (1 entry clock plus 4 HOLD clocks).
REQ-040 The block SHALL NOT check FIFO underflow in BURST; the WAIT precondition guarantees 16 words are present.

Reset
REQ-041 While csi_global_reset_n=0, the state SHALL be IDLE.
REQ-042 While csi_global_reset_n=0, done SHALL be 1, and avm_m1_write and fifo_rdack SHALL be 0.
REQ-043 While csi_global_reset_n=0, the address register, remaining-cycle counter, beat counter and HOLD counter SHALL be 0.
REQ-044 Reset SHALL take effect asynchronously, including mid-burst, and SHALL abandon any partial burst.
REQ-045 Reset release SHALL be synchronous to avm_m1_clk.
REQ-046 After reset release, the first start SHALL be honoured on the first rising edge.

Verification
REQ-047 Scenario 1: start with addr=0x1000_0000, num=2, FIFO holding 32 words, waitrequest=0 -> two bursts of 16 at 0x1000_0000 and 0x1000_0040, 32 rdacks, done low throughout, then done high 4 clocks after the last beat.
REQ-048 Scenario 2: waitrequest toggling every other clock during a burst -> address, data and burstcount stable while stalled, exactly 16 accepts, no extra rdack.
REQ-049 Scenario 3: num=1 with fifo_usedw=15 for 20 clocks, then 16 -> remains in WAIT with write=0 for 20 clocks, then one burst.
REQ-050 Scenario 4: addr=0xFFFF_FFC0, num=2 -> second burst address is 0x0000_0000.
REQ-051 Scenario 5: num=0 -> no write, done low for 5 clocks; a second start during that low period is ignored.
REQ-052 Scenario 6: reset asserted at beat 7 -> write and rdack drop immediately, done=1; a fresh start then runs a complete frame.
